// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I-cache/D-cache fill paths, the arbiter and main memory.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;

  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;

  logic        err;

  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_done;
  logic [15:0] mem_rdata;

  logic [15:0] i_grant_cnt;
  logic [15:0] d_grant_cnt;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_done, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, err,
           mem_en, mem_wr, mem_addr, mem_wdata, i_grant_cnt, d_grant_cnt
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_done, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, err,
           mem_en, mem_wr, mem_addr, mem_wdata, i_grant_cnt, d_grant_cnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter: D-cache priority with an I-cache starvation guard,
// one transaction at a time through IDLE/ISSUE/WAIT/RESP, all outputs registered.
module mem_arbiter #(
  parameter int STARVE_LIM = 3,
  parameter int TIMEOUT    = 31
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIM + 2);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [TW-1:0] TOUT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q;
  logic          owner_d_q;
  logic [SW-1:0] starve_q;
  logic [TW-1:0] tcnt_q;
  logic [15:0]   i_cnt_q;
  logic [15:0]   d_cnt_q;

  logic          i_done_q;
  logic          d_done_q;
  logic          err_q;
  logic [15:0]   i_rdata_q;
  logic [15:0]   d_rdata_q;
  logic          mem_en_q;
  logic          mem_wr_q;
  logic [15:0]   mem_addr_q;
  logic [15:0]   mem_wdata_q;

  logic          gnt_i_d;
  logic          gnt_d_d;
  logic [SW-1:0] starve_d;
  logic          rsp_fire_d;
  logic          rsp_err_d;
  logic [15:0]   rsp_data_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [SW-1:0] sat_starve(input logic [SW-1:0] v);
    return (v >= STARVE_MAX) ? STARVE_MAX : v + SW'(1);
  endfunction

  // Arbitration: D wins unless I has been passed over STARVE_LIM times in a row.
  always_comb begin
    gnt_i_d  = 1'b0;
    gnt_d_d  = 1'b0;
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (bus.d_req && !(bus.i_req && (starve_q == STARVE_MAX))) begin
        gnt_d_d = 1'b1;
      end else if (bus.i_req) begin
        gnt_i_d = 1'b1;
      end
    end
    if (gnt_d_d) begin
      starve_d = bus.i_req ? sat_starve(starve_q) : '0;
    end else if (gnt_i_d) begin
      starve_d = '0;
    end
  end

  // Response decision: memory completion wins over a simultaneous timeout.
  always_comb begin
    rsp_fire_d = 1'b0;
    rsp_err_d  = 1'b0;
    if (((state_q == ISSUE) || (state_q == WAIT)) && bus.mem_done) begin
      rsp_fire_d = 1'b1;
    end else if ((state_q == WAIT) && (tcnt_q == TOUT_LAST)) begin
      rsp_fire_d = 1'b1;
      rsp_err_d  = 1'b1;
    end
    rsp_data_d = rsp_err_d ? 16'h0000 : bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      starve_q    <= '0;
      tcnt_q      <= '0;
      i_cnt_q     <= '0;
      d_cnt_q     <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Pulsed outputs default low; data outputs are zero whenever not qualified.
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      starve_q    <= starve_d;

      case (state_q)
        IDLE: begin
          if (gnt_d_d || gnt_i_d) begin
            owner_d_q   <= gnt_d_d;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= gnt_d_d & bus.d_wr;
            mem_addr_q  <= gnt_d_d ? bus.d_addr : bus.i_addr;
            mem_wdata_q <= gnt_d_d ? bus.d_wdata : 16'h0000;
            if (gnt_d_d) begin
              d_cnt_q <= sat_inc16(d_cnt_q);
            end else begin
              i_cnt_q <= sat_inc16(i_cnt_q);
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          tcnt_q <= tcnt_q + TW'(1);
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (rsp_fire_d) begin
        i_done_q  <= ~owner_d_q;
        d_done_q  <= owner_d_q;
        i_rdata_q <= owner_d_q ? 16'h0000 : rsp_data_d;
        d_rdata_q <= owner_d_q ? rsp_data_d : 16'h0000;
        err_q     <= rsp_err_d;
        state_q   <= RESP;
      end
    end
  end

  assign bus.i_done      = i_done_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_done      = d_done_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.err         = err_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.i_grant_cnt = i_cnt_q;
  assign bus.d_grant_cnt = d_cnt_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported main memory between the I-cache fill path and the D-cache fill/writeback path of the pipelined processor.
- Grants one requester at a time and sequences a single memory transaction through issue, wait and response.
- D-cache has priority, with a starvation guard for the I-cache.
- Keeps saturating grant counters that the bench reads for ICacheReq/DCacheReq accounting.

Parameters:
- STARVE_LIM, 3: maximum consecutive D grants while I is requesting before I is forced.
- TIMEOUT, 31: maximum cycles spent in WAIT before the transaction is aborted with an error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- i_req  in  1  I-cache request (read only); held until i_done.
- i_addr  in  16  I-cache word address.
- i_done  out  1  one-cycle pulse: I transaction complete.
- i_rdata  out  16  read data for I; valid while i_done=1.
- d_req  in  1  D-cache request; held until d_done.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  16  D-cache word address.
- d_wdata  in  16  D-cache write data.
- d_done  out  1  one-cycle pulse: D transaction complete.
- d_rdata  out  16  read data for D; valid while d_done=1.
- err  out  1  pulse coincident with i_done/d_done when the transaction timed out.
- mem_en  out  1  one-cycle command strobe to memory.
- mem_wr  out  1  command is a write.
- mem_addr  out  16  command address.
- mem_wdata  out  16  command write data.
- mem_done  in  1  memory completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  16  memory read data.
- i_grant_cnt  out  16  number of I grants, saturating at 0xFFFF.
- d_grant_cnt  out  16  number of D grants, saturating at 0xFFFF.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- Reset (rst=0, asynchronous):
  - state = IDLE; all outputs = 0.
  - owner, starvation and timeout counters cleared; grant counters = 0.
  - Reset asserted mid-transaction drops mem_en immediately. No done pulse follows; the transaction is lost.
- IDLE arbitration, evaluated each cycle:
  - Only d_req: grant D.
  - Only i_req: grant I.
  - Both requesting: grant I if starve_cnt == STARVE_LIM, otherwise grant D.
  - Neither requesting: stay in IDLE.
- On grant:
  - Latch owner, addr, wr (forced 0 for I) and wdata.
  - Increment the owner's grant counter, saturating.
  - Next state = ISSUE.
- Starvation counter:
  - starve_cnt increments when D is granted while i_req=1.
  - It clears on any I grant, or on a D grant while i_req=0.
  - It saturates at STARVE_LIM.
- ISSUE (exactly one cycle):
  - mem_en=1; mem_wr, mem_addr and mem_wdata are driven from the latched values.
  - mem_done=1 in this cycle: capture mem_rdata, go to RESP.
  - Otherwise go to WAIT and clear the timeout counter.
- WAIT:
  - mem_en=0.
  - mem_done=1: capture mem_rdata, go to RESP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, go to RESP with err_pend set and rdata = 0x0000.
- RESP (one cycle):
  - The owner's done=1 and its rdata = captured value.
  - err = err_pend; the other requester's done stays 0.
  - Next state = IDLE. One bubble cycle is enforced: no new grant occurs in RESP.
- Latency:
  - Request seen in IDLE at cycle N.
  - mem_en at N+1.
  - With mem_done at cycle M ≥ N+1, done is at M+1.
  - Minimum request-to-done is 2 cycles.
- Requester inputs are sampled only at grant; changes afterwards are ignored.
- A requester that drops req before done still receives the done pulse.
- For writes, rdata carries the mem_rdata value captured at mem_done and has no meaning.
- mem_done outside ISSUE/WAIT is ignored.
- Every data output is 0 in any cycle where its done is 0.

Test Plan:
- Single I read: i_req=1, i_addr=0x0040, memory returns 0x1234 two cycles after mem_en -> mem_en one cycle with mem_addr=0x0040 and mem_wr=0; i_done plus i_rdata=0x1234 one cycle after mem_done; i_grant_cnt=1.
- D write: d_req=1, d_wr=1, d_addr=0x0100, d_wdata=0xBEEF -> mem_en with mem_wr=1, mem_addr=0x0100, mem_wdata=0xBEEF; d_done pulses once; i_done stays 0.
- Priority and starvation: i_req and d_req held continuously with STARVE_LIM=3 -> grant order D,D,D,I,D,D,D,I; exactly one bubble cycle between transactions; counters 6 and 2 after 8 grants.
- Zero-wait memory: mem_done asserted during the ISSUE cycle -> done exactly 2 cycles after the request is first seen; no WAIT state entered.
- Timeout: mem_done never asserted -> done and err pulse together after TIMEOUT WAIT cycles with rdata=0x0000; the next request proceeds normally.
- Reset mid-WAIT: rst driven to 0 asynchronously -> mem_en, done and counters go to 0 immediately; after release, a fresh d_req completes normally with d_grant_cnt=1.
